mux_scan_sequencer: RTL



---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/mux_scan_dwell_cnt.sv | 42 ++++
 rtl/mux_scan_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan sequencer
// Contents: state_e (IDLE/SCAN), default SEL_W/DWELL, num_ch() and cnt_w() helpers.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int DEF_SEL_W = 2;
    localparam int DEF_DWELL = 1;

    function automatic int num_ch(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Counter width for a dwell of 'dwell' cycles; never narrower than one bit.
    function automatic int cnt_w(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// rtl/mux_scan_dwell_cnt.sv - per-channel dwell down-counter producing the capture strobe
// Ports: clk, rst_n (async active-low), load (arm for a new scan), en (count while scanning),
//        expire (high in the cycle whose closing edge is the capture edge).
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int            CW     = cnt_w(DWELL);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reloads itself on expiry so the next channel gets a full dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    assign expire = en && !load && (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4-to-1 style mux through its channels and captures each bit
// Ports: clk, rst_n (async active-low), start, mux_out (from mux), sel (to mux), busy,
//        done (1-cycle pulse on result update), result (bit n = mux_out while sel == n),
//        stop (only with MUX_SCAN_CONT_EN: ends continuous rescanning after the current scan).
// Build option: MUX_SCAN_CONT_EN enables continuous rescanning until stop.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mux_out,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic [2**SEL_W-1:0]   result
`ifdef MUX_SCAN_CONT_EN
    ,
    input  logic                  stop
`endif
);

    localparam int               NUM_CH  = num_ch(SEL_W);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   result_q, result_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;

    logic expire;
    logic cnt_load;
    logic cnt_en;
    logic rescan;

`ifdef MUX_SCAN_CONT_EN
    assign rescan = ~stop;
`else
    assign rescan = 1'b0;
`endif

    assign cnt_load = (state_q == IDLE) && start;
    assign cnt_en   = (state_q == SCAN);

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .en     (cnt_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (expire) begin
                    shadow_d[sel_q] = mux_out;
                    if (sel_q == LAST_CH) begin
                        // shadow_d already carries the last channel's bit, so the
                        // result is published without waiting a cycle.
                        result_d = shadow_d;
                        done_d   = 1'b1;
                        sel_d    = '0;
                        if (!rescan) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sel    = sel_q;
        busy   = busy_q;
        done   = done_q;
        result = result_q;
    end

endmodule
